// File: rtl/cpu_pkg.sv
// Shared widths and forward-select encoding for the MIPS core pipeline.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_e;
endpackage

// File: rtl/id_operand_stage_if.sv
// Decode/operand-fetch stage signal bundle; slave is the stage, master drives it.
interface id_operand_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CTRL_W = cpu_pkg::CTRL_W
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt;
  logic              id_rs_used, id_rt_used;
  logic [DATA_W-1:0] id_imm, id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_wreg;
  logic [REG_AW-1:0] id_waddr;
  logic              id_is_load;
  logic [REG_AW-1:0] rf_raddr1, rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
  logic              ex_valid, ex_wreg, ex_is_load;
  logic [REG_AW-1:0] ex_waddr;
  logic [DATA_W-1:0] ex_wdata;
  logic              mem_valid, mem_wreg, mem_is_load, mem_load_ready;
  logic [REG_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wb_we;
  logic [REG_AW-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              ex_stall, flush;
  logic              id_stall;
  logic              ie_valid, ie_wreg, ie_is_load;
  logic [DATA_W-1:0] ie_opa, ie_opb, ie_imm, ie_pc;
  logic [CTRL_W-1:0] ie_ctrl;
  logic [REG_AW-1:0] ie_waddr, ie_rs, ie_rt;
  logic [31:0]       stall_cnt;
  fwd_e              fwd_a, fwd_b;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_imm, id_pc, id_ctrl,
           id_wreg, id_waddr, id_is_load, rf_rdata1, rf_rdata2,
           ex_valid, ex_wreg, ex_is_load, ex_waddr, ex_wdata,
           mem_valid, mem_wreg, mem_is_load, mem_load_ready, mem_waddr, mem_wdata,
           wb_we, wb_waddr, wb_wdata, ex_stall, flush,
    output rf_raddr1, rf_raddr2, id_stall, ie_valid, ie_wreg, ie_is_load,
           ie_opa, ie_opb, ie_imm, ie_pc, ie_ctrl, ie_waddr, ie_rs, ie_rt,
           stall_cnt, fwd_a, fwd_b
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_imm, id_pc, id_ctrl,
           id_wreg, id_waddr, id_is_load, rf_rdata1, rf_rdata2,
           ex_valid, ex_wreg, ex_is_load, ex_waddr, ex_wdata,
           mem_valid, mem_wreg, mem_is_load, mem_load_ready, mem_waddr, mem_wdata,
           wb_we, wb_waddr, wb_wdata, ex_stall, flush,
    input  rf_raddr1, rf_raddr2, id_stall, ie_valid, ie_wreg, ie_is_load,
           ie_opa, ie_opb, ie_imm, ie_pc, ie_ctrl, ie_waddr, ie_rs, ie_rt,
           stall_cnt, fwd_a, fwd_b
  );
endinterface

// File: rtl/fwd_sel.sv
// Resolves one source operand: zero, EX, MEM, WB forward, else register file.
// A load still in flight on the matching path flags a hazard if the source is read.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              used,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              ex_valid,
  input  logic              ex_wreg,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              mem_valid,
  input  logic              mem_wreg,
  input  logic              mem_is_load,
  input  logic              mem_load_ready,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] operand,
  output fwd_e              sel,
  output logic              hazard
);
  logic live;
  assign live = id_valid & used;

  always_comb begin
    operand = rf_rdata;
    sel     = FWD_RF;
    hazard  = 1'b0;
    if (addr == '0) begin
      operand = '0;
      sel     = FWD_ZERO;
    end else if (ex_valid && ex_wreg && ex_waddr == addr) begin
      operand = ex_wdata;
      sel     = FWD_EX;
      hazard  = ex_is_load & live;
    end else if (mem_valid && mem_wreg && mem_waddr == addr) begin
      operand = mem_wdata;
      sel     = FWD_MEM;
      hazard  = mem_is_load & ~mem_load_ready & live;
    end else if (wb_we && wb_waddr == addr) begin
      // RF write ordering within the cycle is not relied upon
      operand = wb_wdata;
      sel     = FWD_WB;
    end
  end
endmodule

// File: rtl/id_operand_stage.sv
// ID operand fetch with EX/MEM/WB forwarding, load-use stall and the ID/EX register.
module id_operand_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CTRL_W = cpu_pkg::CTRL_W
) (
  input logic          clk,
  input logic          rst,
  id_operand_stage_if.slave bus
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] opa, opb;
  logic              haz_a, haz_b, hazard, stall;
  fwd_e              sel_a, sel_b;

  assign bus.rf_raddr1 = bus.id_rs;
  assign bus.rf_raddr2 = bus.id_rt;

  fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .addr(bus.id_rs), .used(bus.id_rs_used), .id_valid(bus.id_valid), .rf_rdata(bus.rf_rdata1),
    .ex_valid(bus.ex_valid), .ex_wreg(bus.ex_wreg), .ex_is_load(bus.ex_is_load),
    .ex_waddr(bus.ex_waddr), .ex_wdata(bus.ex_wdata),
    .mem_valid(bus.mem_valid), .mem_wreg(bus.mem_wreg), .mem_is_load(bus.mem_is_load),
    .mem_load_ready(bus.mem_load_ready), .mem_waddr(bus.mem_waddr), .mem_wdata(bus.mem_wdata),
    .wb_we(bus.wb_we), .wb_waddr(bus.wb_waddr), .wb_wdata(bus.wb_wdata),
    .operand(opa), .sel(sel_a), .hazard(haz_a)
  );

  fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .addr(bus.id_rt), .used(bus.id_rt_used), .id_valid(bus.id_valid), .rf_rdata(bus.rf_rdata2),
    .ex_valid(bus.ex_valid), .ex_wreg(bus.ex_wreg), .ex_is_load(bus.ex_is_load),
    .ex_waddr(bus.ex_waddr), .ex_wdata(bus.ex_wdata),
    .mem_valid(bus.mem_valid), .mem_wreg(bus.mem_wreg), .mem_is_load(bus.mem_is_load),
    .mem_load_ready(bus.mem_load_ready), .mem_waddr(bus.mem_waddr), .mem_wdata(bus.mem_wdata),
    .wb_we(bus.wb_we), .wb_waddr(bus.wb_waddr), .wb_wdata(bus.wb_wdata),
    .operand(opb), .sel(sel_b), .hazard(haz_b)
  );

  assign hazard       = haz_a | haz_b;
  // flush does not mask the stall; the redirect is handled upstream
  assign stall        = hazard | bus.ex_stall;
  assign bus.id_stall = stall;
  assign bus.fwd_a    = sel_a;
  assign bus.fwd_b    = sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ie_valid   <= 1'b0;
      bus.ie_wreg    <= 1'b0;
      bus.ie_is_load <= 1'b0;
      bus.ie_opa     <= '0;
      bus.ie_opb     <= '0;
      bus.ie_imm     <= '0;
      bus.ie_pc      <= '0;
      bus.ie_ctrl    <= '0;
      bus.ie_waddr   <= '0;
      bus.ie_rs      <= '0;
      bus.ie_rt      <= '0;
      bus.stall_cnt  <= '0;
    end else begin
      if (bus.id_valid && stall && !bus.flush && bus.stall_cnt != 32'hFFFF_FFFF)
        bus.stall_cnt <= bus.stall_cnt + 32'd1;

      if (bus.flush || (hazard && !bus.ex_stall)) begin
        bus.ie_valid <= 1'b0;
        bus.ie_wreg  <= 1'b0;
      end else if (!bus.ex_stall) begin
        bus.ie_valid   <= bus.id_valid;
        bus.ie_wreg    <= bus.id_wreg & bus.id_valid;
        bus.ie_is_load <= bus.id_is_load;
        bus.ie_opa     <= opa;
        bus.ie_opb     <= opb;
        bus.ie_imm     <= bus.id_imm;
        bus.ie_pc      <= bus.id_pc;
        bus.ie_ctrl    <= bus.id_ctrl;
        bus.ie_waddr   <= bus.id_waddr;
        bus.ie_rs      <= bus.id_rs;
        bus.ie_rt      <= bus.id_rt;
      end
    end
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: expectations queued at drive time, popped after the edge.
module tb_id_operand_stage;
  import cpu_pkg::*;

  typedef struct {
    string       tag;
    logic        valid;
    logic        wreg;
    logic        chk_opa;
    logic [31:0] opa;
    logic        chk_opb;
    logic [31:0] opb;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  id_operand_stage_if bus ();

  id_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0;
    bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0;
    bus.id_imm = '0; bus.id_pc = '0; bus.id_ctrl = '0;
    bus.id_wreg = 1'b0; bus.id_waddr = '0; bus.id_is_load = 1'b0;
    bus.rf_rdata1 = '0; bus.rf_rdata2 = '0;
    bus.ex_valid = 1'b0; bus.ex_wreg = 1'b0; bus.ex_is_load = 1'b0;
    bus.ex_waddr = '0; bus.ex_wdata = '0;
    bus.mem_valid = 1'b0; bus.mem_wreg = 1'b0; bus.mem_is_load = 1'b0;
    bus.mem_load_ready = 1'b0; bus.mem_waddr = '0; bus.mem_wdata = '0;
    bus.wb_we = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0;
    bus.ex_stall = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic consumer(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] rd1, input logic [31:0] rd2);
    bus.id_valid = 1'b1; bus.id_wreg = 1'b1; bus.id_waddr = 5'd9;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rs_used = 1'b1; bus.id_rt_used = 1'b1;
    bus.rf_rdata1 = rd1; bus.rf_rdata2 = rd2;
  endtask

  task automatic ex_prod(input logic [4:0] a, input logic [31:0] d, input logic ld);
    bus.ex_valid = 1'b1; bus.ex_wreg = 1'b1; bus.ex_waddr = a; bus.ex_wdata = d; bus.ex_is_load = ld;
  endtask

  task automatic mem_prod(input logic [4:0] a, input logic [31:0] d, input logic ld, input logic rdy);
    bus.mem_valid = 1'b1; bus.mem_wreg = 1'b1; bus.mem_waddr = a; bus.mem_wdata = d;
    bus.mem_is_load = ld; bus.mem_load_ready = rdy;
  endtask

  function automatic exp_t mk(input string tag, input logic v, input logic w,
                              input logic ca, input logic [31:0] a,
                              input logic cb, input logic [31:0] b, input logic [31:0] c);
    exp_t e;
    e.tag = tag; e.valid = v; e.wreg = w; e.chk_opa = ca; e.opa = a;
    e.chk_opb = cb; e.opb = b; e.cnt = c;
    return e;
  endfunction

  // Inputs are already driven (after a negedge); check the stall, then the captured result.
  task automatic step(input logic exp_stall, input exp_t e);
    exp_t g;
    #1;
    check({e.tag, "_id_stall"}, 32'(bus.id_stall), 32'(exp_stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({g.tag, "_ie_valid"}, 32'(bus.ie_valid), 32'(g.valid));
    check({g.tag, "_ie_wreg"}, 32'(bus.ie_wreg), 32'(g.wreg));
    if (g.chk_opa) check({g.tag, "_ie_opa"}, bus.ie_opa, g.opa);
    if (g.chk_opb) check({g.tag, "_ie_opb"}, bus.ie_opb, g.opb);
    check({g.tag, "_stall_cnt"}, bus.stall_cnt, g.cnt);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ie_valid", 32'(bus.ie_valid), 32'd0);
    check("rst_ie_opa", bus.ie_opa, 32'd0);
    check("rst_stall_cnt", bus.stall_cnt, 32'd0);
    rst = 1'b0;

    // EX beats MEM for r3
    consumer(5'd3, 5'd4, 32'h1000, 32'h2000);
    bus.id_imm = 32'h1234; bus.id_pc = 32'h400; bus.id_ctrl = 16'hBEEF;
    ex_prod(5'd3, 32'h11, 1'b0);
    mem_prod(5'd3, 32'h22, 1'b0, 1'b0);
    #1;
    check("s1_raddr1", 32'(bus.rf_raddr1), 32'd3);
    check("s1_fwd_a", 32'(bus.fwd_a), 32'(FWD_EX));
    step(1'b0, mk("s1", 1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 32'h2000, 32'd0));
    check("s1_ie_imm", bus.ie_imm, 32'h1234);
    check("s1_ie_pc", bus.ie_pc, 32'h400);
    check("s1_ie_ctrl", 32'(bus.ie_ctrl), 32'hBEEF);
    check("s1_ie_waddr", 32'(bus.ie_waddr), 32'd9);

    // r0 forced to zero even when EX claims to write it
    consumer(5'd3, 5'd0, 32'h1000, 32'hFFFF);
    bus.id_wreg = 1'b0;
    ex_prod(5'd0, 32'h55, 1'b0);
    mem_prod(5'd3, 32'h22, 1'b0, 1'b0);
    step(1'b0, mk("s2", 1'b1, 1'b0, 1'b1, 32'h22, 1'b1, 32'h0, 32'd0));

    // load-use: one bubble, then MEM forwards the load data
    consumer(5'd5, 5'd4, 32'h0, 32'h2000);
    ex_prod(5'd5, 32'hDEAD, 1'b1);
    step(1'b1, mk("s3", 1'b0, 1'b0, 1'b1, 32'h22, 1'b1, 32'h0, 32'd1));
    consumer(5'd5, 5'd4, 32'h0, 32'h2000);
    mem_prod(5'd5, 32'hABCD, 1'b1, 1'b1);
    step(1'b0, mk("s4", 1'b1, 1'b1, 1'b1, 32'hABCD, 1'b1, 32'h2000, 32'd1));

    // ex_stall holds everything, counts a stalled cycle
    consumer(5'd8, 5'd4, 32'h8888, 32'h4444);
    bus.ex_stall = 1'b1;
    step(1'b1, mk("s5", 1'b1, 1'b1, 1'b1, 32'hABCD, 1'b1, 32'h2000, 32'd2));

    // MEM load not ready yet on rt
    consumer(5'd1, 5'd6, 32'h1111, 32'h6666);
    mem_prod(5'd6, 32'h0, 1'b1, 1'b0);
    step(1'b1, mk("s6", 1'b0, 1'b0, 1'b1, 32'hABCD, 1'b1, 32'h2000, 32'd3));

    // load match on an unused source does not stall
    consumer(5'd5, 5'd2, 32'h0, 32'h2222);
    bus.id_rs_used = 1'b0;
    ex_prod(5'd5, 32'h99, 1'b1);
    step(1'b0, mk("s7", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2222, 32'd3));

    // flush beats ex_stall and hazard; count does not move
    consumer(5'd5, 5'd4, 32'h0, 32'h4444);
    ex_prod(5'd5, 32'h0, 1'b1);
    bus.ex_stall = 1'b1; bus.flush = 1'b1;
    step(1'b1, mk("s8", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2222, 32'd3));

    // WB-only match overrides stale RF data
    consumer(5'd7, 5'd0, 32'h0, 32'h0);
    bus.wb_we = 1'b1; bus.wb_waddr = 5'd7; bus.wb_wdata = 32'h77;
    #1;
    check("s9_fwd_a", 32'(bus.fwd_a), 32'(FWD_WB));
    step(1'b0, mk("s9", 1'b1, 1'b1, 1'b1, 32'h77, 1'b1, 32'h0, 32'd3));

    // reset in the middle of a stall
    consumer(5'd5, 5'd4, 32'h0, 32'h4444);
    bus.id_pc = 32'h800;
    ex_prod(5'd5, 32'h0, 1'b1);
    rst = 1'b1;
    step(1'b1, mk("s10", 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0, 32'd0));
    check("s10_ie_pc", bus.ie_pc, 32'h0);
    check("s10_ie_ctrl", 32'(bus.ie_ctrl), 32'h0);
    rst = 1'b0;

    consumer(5'd3, 5'd4, 32'h33, 32'h44);
    step(1'b0, mk("s11", 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 32'h44, 32'd0));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
